multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore/Mealy control FSM for the project-2 multicycle MIPS datapath.
- Sequences one instruction over 3–5 states by driving every datapath mux select (IorD, ALUSrcA/B, PCSource, RegDst, MemtoReg) and every write enable (PC, IR, register file, memory).
- Handshakes with a variable-latency memory and enters a sticky halt state on a memory timeout.
- Sits beside the datapath; consumes only the IR opcode field and memory ready.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent waiting for mem_ready_i in any memory state before halting (legal range 2..255).
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk_i, in, 1: clock, rising edge.
- rst_i, in, 1: asynchronous, active-low reset.
- opcode_i, in, 6: IR[31:26]; sampled only in DECODE.
- mem_ready_i, in, 1: memory completes the current read/write this cycle.
- pc_write_o, out, 1: unconditional PC write.
- pc_write_cond_o, out, 1: PC write if ALU zero (beq).
- iord_o, out, 1: memory address mux; 0 = PC, 1 = ALUOut.
- mem_read_o, out, 1: memory read request.
- mem_write_o, out, 1: memory write request.
- ir_write_o, out, 1: IR load.
- mem_to_reg_o, out, 1: write-back mux; 0 = ALUOut, 1 = MDR.
- reg_dst_o, out, 1: destination mux; 0 = rt, 1 = rd.
- reg_write_o, out, 1: register file write.
- alu_src_a_o, out, 1: ALU A mux; 0 = PC, 1 = A.
- alu_src_b_o, out, 2: ALU B mux; 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op_o, out, 2: ALU op; 00 = add, 01 = sub, 10 = funct.
- pc_source_o, out, 2: PC mux; 00 = ALU, 01 = ALUOut, 10 = jump target.
- illegal_o, out, 1: one-cycle pulse on an undefined opcode.
- halt_o, out, 1: sticky; asserted in HALT.
- state_o, out, 4: current state encoding, for debug.

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, REXEC=7, RWB=8, BEQ=9, JUMP=10, ADDIEX=11, ADDIWB=12, HALT=15.
- Reset: while rst_i=0, state=IDLE, wait counter=0, and every output is 0, including state_o. Reset asserted mid-instruction aborts it immediately; no further write enables are issued.
- IDLE: all outputs 0 (selects take their 0 encoding). Next state is FETCH, unconditionally.
- FETCH: mem_read_o=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write_o and pc_write_o equal mem_ready_i (Mealy). Next state is DECODE when mem_ready_i=1; otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch-target precompute). Next state by opcode:
  - 000000 (R-type) → REXEC
  - 100011 (lw) or 101011 (sw) → MEMADR
  - 000100 (beq) → BEQ
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDIEX
  - any other opcode → FETCH, with illegal_o=1 for that DECODE cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read_o=1, iord=1. Next state is MEMWB on mem_ready_i; otherwise stay.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state is FETCH.
- MEMWR: mem_write_o=1, iord=1. Next state is FETCH on mem_ready_i; otherwise stay.
- REXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state is RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state is FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next state is FETCH.
- JUMP: pc_write=1, pc_source=10. Next state is FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state is FETCH.
- HALT: all enables 0 and halt_o=1. Leaves only via reset.
- Wait counter (memory states FETCH, MEMRD, MEMWR):
  - Clears on entry to any memory state.
  - Increments each cycle in that state while mem_ready_i=0.
  - If it reaches MEM_TIMEOUT−1 with mem_ready_i still 0, next state is HALT.
  - If mem_ready_i=1 in that same cycle, completion wins: normal transition, no halt.
- Outputs not listed for a state are 0.
- Instruction latencies (zero memory wait):
  - 3 cycles: beq, j
  - 4 cycles: R-type, addi, sw
  - 5 cycles: lw
  - Each memory state adds one cycle per cycle of mem_ready_i=0.
- mem_ready_i is ignored outside FETCH, MEMRD and MEMWR.

Decomposition:
- Package multicycle_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - 4-bit state encodings;
  - ALUOp, ALUSrcB and PCSource encodings.
- One sub-module, mc_mem_wait_timer:
  - inputs clear, count_en, mem_ready_i;
  - output timeout;
  - parameterised by MEM_TIMEOUT and CNT_W.
- FSM next-state logic and output decode stay in multicycle_ctrl.

Test Plan:
- Reset, then mem_ready_i=1 every cycle, opcode 000000 → state_o sequence 0,1,2,7,8,1; reg_write_o=1 with reg_dst_o=1 only in cycle 5.
- lw (100011), mem_ready_i held 0 for 3 cycles in MEMRD → states 1,2,3,4,4,4,4,5,1; iord_o=1 throughout MEMRD; mem_to_reg_o=1 in MEMWB.
- beq then j, zero wait → 3 cycles each; pc_write_cond_o=1 with pc_source_o=01 in BEQ; pc_write_o=1 with pc_source_o=10 in JUMP.
- opcode 111111 → illegal_o pulses exactly one cycle in DECODE, next state FETCH, no write enables asserted.
- mem_ready_i=0 forever in FETCH, MEM_TIMEOUT=16 → HALT entered after 16 FETCH cycles; halt_o stays 1 for 100 cycles; ir_write_o never asserted.
- rst_i driven low asynchronously mid-MEMWR → mem_write_o drops to 0 without waiting for a clock edge; after release, IDLE then FETCH.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle MIPS control unit.
// Opcodes, FSM state codes and datapath mux select values.
package multicycle_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REXEC  = 4'd7,
        S_RWB    = 4'd8,
        S_BEQ    = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_mem_wait_timer.sv
// Counts stalled cycles in a memory state and flags a timeout
// on the last permitted stalled cycle (MEM_TIMEOUT-1).
module mc_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic count_en_i,
    input  logic mem_ready_i,
    output logic timeout_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_limit;

    assign w_at_limit = (r_cnt == LIMIT);

    // Wait counter: restart on state change, step on each stall, hold at limit
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (count_en_i && !mem_ready_i && !w_at_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A ready in the same cycle as the limit means completion, not timeout
    assign timeout_o = count_en_i && !mem_ready_i && w_at_limit;

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle MIPS datapath: sequences each
// instruction, handshakes with memory and halts on a memory timeout.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       mem_to_reg_o,
    output logic       reg_dst_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] pc_source_o,
    output logic       illegal_o,
    output logic       halt_o,
    output logic [3:0] state_o
);

    state_t r_state;
    state_t w_next;
    logic   r_is_sw;
    logic   w_timeout;
    logic   w_mem_state;
    logic   w_clear;

    assign w_mem_state = (r_state == S_FETCH) ||
                         (r_state == S_MEMRD) ||
                         (r_state == S_MEMWR);
    assign w_clear     = (w_next != r_state);
    assign state_o     = r_state;

    mc_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (w_clear),
        .count_en_i  (w_mem_state),
        .mem_ready_i (mem_ready_i),
        .timeout_o   (w_timeout)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Remember lw vs sw at decode so MEMADR ignores later opcode changes
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_is_sw <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_is_sw <= (opcode_i == OP_SW);
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        w_next          = r_state;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_dst_o       = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRCB_B;
        alu_op_o        = ALUOP_ADD;
        pc_source_o     = PCSRC_ALU;
        illegal_o       = 1'b0;
        halt_o          = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                if (mem_ready_i) begin
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_DECODE: begin
                alu_src_b_o = SRCB_IMM_SH2;
                case (opcode_i)
                    OP_RTYPE: w_next = S_REXEC;
                    OP_LW:    w_next = S_MEMADR;
                    OP_SW:    w_next = S_MEMADR;
                    OP_BEQ:   w_next = S_BEQ;
                    OP_J:     w_next = S_JUMP;
                    OP_ADDI:  w_next = S_ADDIEX;
                    default: begin
                        w_next    = S_FETCH;
                        illegal_o = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                w_next      = r_is_sw ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
                if (mem_ready_i) begin
                    w_next = S_MEMWB;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_MEMWB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
                if (mem_ready_i) begin
                    w_next = S_FETCH;
                end else if (w_timeout) begin
                    w_next = S_HALT;
                end
            end
            S_REXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALUOP_FUNCT;
                w_next      = S_RWB;
            end
            S_RWB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
                w_next      = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = ALUOP_SUB;
                pc_write_cond_o = 1'b1;
                pc_source_o     = PCSRC_ALUOUT;
                w_next          = S_FETCH;
            end
            S_JUMP: begin
                pc_write_o  = 1'b1;
                pc_source_o = PCSRC_JUMP;
                w_next      = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                w_next      = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_o = 1'b1;
                w_next      = S_FETCH;
            end
            S_HALT: begin
                halt_o = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle check against an
// instruction-level model plus literal spot checks.
module tb_multicycle_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [5:0] opcode_i = 6'd0;
    logic       mem_ready_i = 1'b0;
    logic       pc_write_o, pc_write_cond_o, iord_o, mem_read_o;
    logic       mem_write_o, ir_write_o, mem_to_reg_o, reg_dst_o;
    logic       reg_write_o, alu_src_a_o, illegal_o, halt_o;
    logic [1:0] alu_src_b_o, alu_op_o, pc_source_o;
    logic [3:0] state_o;

    int nerr = 0;
    int nchk = 0;
    int hist[$];
    int irw_seen = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i),
        .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o),
        .pc_write_cond_o(pc_write_cond_o), .iord_o(iord_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .ir_write_o(ir_write_o), .mem_to_reg_o(mem_to_reg_o),
        .reg_dst_o(reg_dst_o), .reg_write_o(reg_write_o),
        .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .alu_op_o(alu_op_o), .pc_source_o(pc_source_o),
        .illegal_o(illegal_o), .halt_o(halt_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [17:0] got_vec();
        return {pc_write_o, pc_write_cond_o, iord_o, mem_read_o,
                mem_write_o, ir_write_o, mem_to_reg_o, reg_dst_o,
                reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                pc_source_o, illegal_o, halt_o};
    endfunction

    // Output table written straight from the per-state description
    function automatic logic [17:0] exp_vec(int st, logic rdy,
                                            logic [5:0] op);
        logic pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, ill, h;
        logic [1:0] sb, aop, ps;
        {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa, ill, h} = '0;
        sb = 2'b00; aop = 2'b00; ps = 2'b00;
        case (st)
            1:  begin mr = 1; sb = 2'b01; pw = rdy; irw = rdy; end
            2:  begin
                    sb = 2'b11;
                    ill = !(op inside {6'h00, 6'h23, 6'h2b,
                                       6'h04, 6'h02, 6'h08});
                end
            3:  begin sa = 1; sb = 2'b10; end
            4:  begin mr = 1; io = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mw = 1; io = 1; end
            7:  begin sa = 1; aop = 2'b10; end
            8:  begin rw = 1; rd = 1; end
            9:  begin sa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
            10: begin pw = 1; ps = 2'b10; end
            11: begin sa = 1; sb = 2'b10; end
            12: begin rw = 1; end
            15: begin h = 1; end
            default: ;
        endcase
        return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, sa,
                sb, aop, ps, ill, h};
    endfunction

    task automatic chk(string name, int got, int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One model cycle: drive, compare at the falling edge, advance
    task automatic cyc(int st, logic rdy, logic [5:0] op);
        logic [17:0] e, g;
        mem_ready_i = rdy;
        opcode_i    = op;
        @(negedge clk_i);
        e = exp_vec(st, mem_ready_i, opcode_i);
        g = got_vec();
        hist.push_back(int'(state_o));
        if (ir_write_o) irw_seen++;
        nchk++;
        if (state_o != 4'(st) || g != e) begin
            nerr++;
            $display("FAIL cycle@%0t: state %0d vec %h expected state %0d vec %h",
                     $time, state_o, g, st, e);
        end
        @(posedge clk_i);
        #1;
    endtask

    // Expected state walk of one instruction; opcode scrambled after DECODE
    task automatic do_instr(logic [5:0] op, int fw, int mw, output int n);
        logic [5:0] x;
        x = ~op;
        n = 0;
        for (int i = 0; i <= fw; i++) begin cyc(1, i == fw, op); n++; end
        cyc(2, 1'b1, op); n++;
        case (op)
            6'h00: begin cyc(7, 1, x); cyc(8, 1, x); n += 2; end
            6'h23: begin
                cyc(3, 1, x); n++;
                for (int i = 0; i <= mw; i++) begin cyc(4, i == mw, x); n++; end
                cyc(5, 1, x); n++;
            end
            6'h2b: begin
                cyc(3, 1, x); n++;
                for (int i = 0; i <= mw; i++) begin cyc(6, i == mw, x); n++; end
            end
            6'h04: begin cyc(9, 1, x); n++; end
            6'h02: begin cyc(10, 1, x); n++; end
            6'h08: begin cyc(11, 1, x); cyc(12, 1, x); n += 2; end
            default: ;
        endcase
    endtask

    initial begin
        int n;
        int lit[6] = '{0, 1, 2, 7, 8, 1};
        rst_i = 1'b0;
        mem_ready_i = 1'b1;
        opcode_i = 6'h23;
        @(negedge clk_i);
        chk("reset_state", int'(state_o), 0);
        chk("reset_outputs", int'(got_vec()), 0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        cyc(0, 1'b1, 6'h00);
        do_instr(6'h00, 0, 0, n);  chk("rtype_latency", n, 4);
        do_instr(6'h23, 0, 3, n);  chk("lw_wait3_latency", n, 8);
        for (int i = 0; i < 6; i++) chk("rtype_state_seq", hist[i], lit[i]);
        chk("lw_memrd_runs", hist[8], 4);
        chk("lw_memwb", hist[12], 5);
        do_instr(6'h04, 0, 0, n);  chk("beq_latency", n, 3);
        do_instr(6'h02, 0, 0, n);  chk("j_latency", n, 3);
        do_instr(6'h3f, 0, 0, n);
        do_instr(6'h08, 2, 0, n);  chk("addi_fw2_latency", n, 6);
        do_instr(6'h2b, 0, 0, n);  chk("sw_latency", n, 4);
        do_instr(6'h2b, 1, 2, n);
        do_instr(6'h23, 0, 15, n);
        do_instr(6'h00, 15, 0, n);
        do_instr(6'h0c, 0, 0, n);
        irw_seen = 0;
        for (int i = 0; i < 16; i++) cyc(1, 1'b0, 6'h00);
        for (int i = 0; i < 100; i++) cyc(15, i[0], 6'h00);
        chk("halt_state", int'(state_o), 15);
        chk("halt_sticky", int'(halt_o), 1);
        chk("no_ir_write_timeout", irw_seen, 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        cyc(0, 1'b1, 6'h2b);
        cyc(1, 1'b1, 6'h2b);
        cyc(2, 1'b1, 6'h2b);
        cyc(3, 1'b1, 6'h00);
        cyc(6, 1'b0, 6'h00);
        cyc(6, 1'b0, 6'h00);
        #2;
        chk("memwr_active", int'(mem_write_o), 1);
        rst_i = 1'b0;
        #1;
        chk("async_reset_memwr", int'(mem_write_o), 0);
        chk("async_reset_state", int'(state_o), 0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        cyc(0, 1'b1, 6'h00);
        do_instr(6'h04, 0, 0, n);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
